ss_slot_ctrl: RTL and testbench

Parametrised save-state slot controller. It turns the OSD level bits for save and load slots into a single-cycle save or restore command with a slot index, then tracks the core's save-state engine through a busy handshake. It is the successor to the fixed 4-slot level decoder. It adds N slots, rising-edge detection, conflict rejection, a one-deep pending request, per-slot validity tracking and a timeout. It sits between hps_io status and the core's ss_index / ss_do_save / ss_do_restore inputs.

---
 rtl/ss_pkg.sv | 30 +++
 rtl/ss_req_decode.sv | 54 +++++
 rtl/ss_slot_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ss_slot_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared types and helpers for the save-state slot controller.
package ss_pkg;

    localparam int unsigned MAX_SLOTS = 16;
    localparam int unsigned SLOT_W    = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} ss_state_t;
    typedef enum logic {SS_SAVE, SS_LOAD} ss_kind_t;

    typedef struct packed {
        ss_kind_t              kind;
        logic [SLOT_W-1:0]     slot;
    } ss_req_t;

    // Index of the lowest set bit; zero when no bit is set.
    function automatic logic [SLOT_W-1:0] lowest_set(input logic [MAX_SLOTS-1:0] v);
        logic [SLOT_W-1:0] idx;
        logic              found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
            if (v[i] && !found) begin
                idx   = SLOT_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ss_req_decode.sv
// Rising-edge detection on the OSD slot bits, lowest-slot priority encode and
// save/load conflict detection; outputs one registered request strobe.
module ss_req_decode
    import ss_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SLOTS-1:0] save_bits,
    input  logic [NUM_SLOTS-1:0] load_bits,
    output logic                 req_valid,
    output ss_req_t              req,
    output logic                 conflict
);

    logic [NUM_SLOTS-1:0] save_prev;
    logic [NUM_SLOTS-1:0] load_prev;
    logic [NUM_SLOTS-1:0] save_rise;
    logic [NUM_SLOTS-1:0] load_rise;
    logic [MAX_SLOTS-1:0] any_rise;
    logic                 primed;
    logic                 both;

    // The first cycle after reset only samples the levels, so a level held
    // across reset is not mistaken for a fresh edge.
    always_comb begin
        save_rise = primed ? (save_bits & ~save_prev) : '0;
        load_rise = primed ? (load_bits & ~load_prev) : '0;
        any_rise  = '0;
        any_rise[NUM_SLOTS-1:0] = save_rise | load_rise;
        both      = (|save_rise) && (|load_rise);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            save_prev <= '0;
            load_prev <= '0;
            primed    <= 1'b0;
            req_valid <= 1'b0;
            req       <= '0;
            conflict  <= 1'b0;
        end else begin
            save_prev <= save_bits;
            load_prev <= load_bits;
            primed    <= 1'b1;
            conflict  <= both;
            req_valid <= (|any_rise) && !both;
            req.kind  <= (|save_rise) ? SS_SAVE : SS_LOAD;
            req.slot  <= lowest_set(any_rise);
        end
    end

endmodule

// File: rtl/ss_slot_ctrl.sv
// Save-state slot controller: turns OSD slot edges into one-cycle save/restore
// commands, tracks the core busy handshake, slot validity and timeouts.
module ss_slot_ctrl
    import ss_pkg::*;
#(
    parameter int unsigned NUM_SLOTS        = 4,
    parameter int unsigned IDX_W            = $clog2(NUM_SLOTS),
    parameter logic [23:0] TIMEOUT          = 24'd8_000_000,
    parameter bit          ALLOW_EMPTY_LOAD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SLOTS-1:0] save_bits,
    input  logic [NUM_SLOTS-1:0] load_bits,
    input  logic                 ss_busy,
    output logic [IDX_W-1:0]     ss_index,
    output logic                 ss_do_save,
    output logic                 ss_do_restore,
    output logic                 active,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic                 reject,
    output logic                 timeout
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 24'd1);

    ss_state_t        state, state_next;
    ss_kind_t         cur_kind;
    logic [IDX_W-1:0] idx_r;
    logic             pend_valid;
    ss_req_t          pend;
    logic [CNT_W-1:0] cnt;

    logic             dec_valid;
    ss_req_t          dec_req;
    logic             dec_conflict;

    logic             empty_load;
    logic             accept;
    logic             take_pend;
    logic             take_new;
    logic             store_new;
    logic             overflow;
    logic             cnt_clear;
    logic             mark_valid;
    logic             unused_slot_hi;

    ss_req_decode #(
        .NUM_SLOTS(NUM_SLOTS)
    ) u_decode (
        .clk       (clk),
        .reset     (reset),
        .save_bits (save_bits),
        .load_bits (load_bits),
        .req_valid (dec_valid),
        .req       (dec_req),
        .conflict  (dec_conflict)
    );

    // Slot index bits above IDX_W are always zero when NUM_SLOTS < 16.
    assign unused_slot_hi = ^pend.slot;
    assign ss_index       = idx_r;

    always_comb begin
        empty_load = dec_valid && (dec_req.kind == SS_LOAD)
                     && !slot_valid[dec_req.slot[IDX_W-1:0]] && !ALLOW_EMPTY_LOAD;
        accept     = dec_valid && !empty_load;

        state_next    = state;
        take_pend     = 1'b0;
        take_new      = 1'b0;
        store_new     = 1'b0;
        overflow      = 1'b0;
        cnt_clear     = 1'b0;
        mark_valid    = 1'b0;
        timeout       = 1'b0;
        ss_do_save    = 1'b0;
        ss_do_restore = 1'b0;
        active        = 1'b0;

        case (state)
            IDLE: begin
                // A queued request wins; a same-cycle new one refills the queue.
                if (pend_valid) begin
                    take_pend  = 1'b1;
                    store_new  = accept;
                    state_next = ISSUE;
                end else if (accept) begin
                    take_new   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                active        = 1'b1;
                ss_do_save    = (cur_kind == SS_SAVE);
                ss_do_restore = (cur_kind == SS_LOAD);
                cnt_clear     = 1'b1;
                state_next    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                active = 1'b1;
                if (ss_busy) begin
                    cnt_clear  = 1'b1;
                    state_next = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                active = 1'b1;
                if (!ss_busy) begin
                    mark_valid = (cur_kind == SS_SAVE);
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state != IDLE && accept) begin
            if (pend_valid) overflow  = 1'b1;
            else            store_new = 1'b1;
        end

        reject = dec_conflict | empty_load | overflow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_kind   <= SS_SAVE;
            idx_r      <= '0;
            pend_valid <= 1'b0;
            pend       <= '0;
            cnt        <= '0;
            slot_valid <= '0;
        end else begin
            state <= state_next;

            if (take_pend) begin
                cur_kind <= pend.kind;
                idx_r    <= pend.slot[IDX_W-1:0];
            end else if (take_new) begin
                cur_kind <= dec_req.kind;
                idx_r    <= dec_req.slot[IDX_W-1:0];
            end

            if (store_new) begin
                pend_valid <= 1'b1;
                pend       <= dec_req;
            end else if (take_pend) begin
                pend_valid <= 1'b0;
            end

            if (cnt_clear)     cnt <= '0;
            else if (cnt != '1) cnt <= cnt + CNT_W'(1);

            if (mark_valid) slot_valid[idx_r] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ss_slot_ctrl.sv
// Scoreboard bench for ss_slot_ctrl: directed stimulus pushes expected pulse
// events (kind, index, cycle); a negedge monitor pops and compares them.
module tb_ss_slot_ctrl;

    localparam int EV_SAVE = 0;
    localparam int EV_REST = 1;
    localparam int EV_REJ  = 2;
    localparam int EV_TMO  = 3;

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] save_bits;
    logic [3:0] load_bits;
    logic       ss_busy;
    logic [1:0] ss_index;
    logic       ss_do_save;
    logic       ss_do_restore;
    logic       active;
    logic [3:0] slot_valid;
    logic       reject;
    logic       timeout;

    int  cyc = 0;
    int  vectors = 0;
    int  errors = 0;
    ev_t exp_q[$];

    ss_slot_ctrl #(
        .NUM_SLOTS        (4),
        .TIMEOUT          (24'd16),
        .ALLOW_EMPTY_LOAD (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .save_bits     (save_bits),
        .load_bits     (load_bits),
        .ss_busy       (ss_busy),
        .ss_index      (ss_index),
        .ss_do_save    (ss_do_save),
        .ss_do_restore (ss_do_restore),
        .active        (active),
        .slot_valid    (slot_valid),
        .reject        (reject),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_SAVE: return "save";
            EV_REST: return "restore";
            EV_REJ:  return "reject";
            default: return "timeout";
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input int idx, input int at);
        ev_t e;
        e.kind = k;
        e.idx  = idx;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic see_event(input int k);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got idx=%0d cyc=%0d, required no event",
                     ev_name(k), ss_index, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.idx != int'(ss_index) || e.cyc != cyc) begin
                errors++;
                $display("FAIL event_%s: got %s idx=%0d cyc=%0d, required %s idx=%0d cyc=%0d",
                         ev_name(e.kind), ev_name(k), ss_index, cyc,
                         ev_name(e.kind), e.idx, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (ss_do_save)    see_event(EV_SAVE);
        if (ss_do_restore) see_event(EV_REST);
        if (reject)        see_event(EV_REJ);
        if (timeout)       see_event(EV_TMO);
    end

    // Full command with a busy pulse of busy_len cycles, then release the levels.
    task automatic run_cmd(input logic [3:0] sb, input logic [3:0] lb,
                           input int idx, input int k, input int busy_len);
        save_bits = sb;
        load_bits = lb;
        push(k, idx, cyc + 2);
        tick(3);
        ss_busy = 1'b1;
        tick(busy_len);
        ss_busy = 1'b0;
        tick(2);
        save_bits = '0;
        load_bits = '0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int c;
        reset     = 1'b1;
        save_bits = '0;
        load_bits = '0;
        ss_busy   = 1'b0;
        tick(3);
        chk("rst_index", 32'(ss_index), 0);
        chk("rst_slot_valid", 32'(slot_valid), 0);
        chk("rst_pulses", 32'({ss_do_save, ss_do_restore, reject, timeout, active}), 0);
        reset = 1'b0;
        tick(2);

        // Basic save to slot 2, held level must not repeat
        save_bits = 4'b0100;
        push(EV_SAVE, 2, cyc + 2);
        tick(2);
        chk("save_active_issue", 32'(active), 1);
        tick(1);
        ss_busy = 1'b1;
        tick(10);
        chk("save_active_wait", 32'(active), 1);
        ss_busy = 1'b0;
        tick(1);
        chk("save_slot_valid", 32'(slot_valid), 32'h4);
        chk("save_active_done", 32'(active), 0);
        tick(5);
        save_bits = '0;
        tick(2);

        // Multi-bit save picks slot 1; load of never-saved slot 3 is rejected
        run_cmd(4'b1010, 4'b0000, 1, EV_SAVE, 2);
        chk("multi_slot_valid", 32'(slot_valid), 32'h6);
        load_bits = 4'b1000;
        push(EV_REJ, 1, cyc + 1);
        tick(4);
        chk("empty_load_active", 32'(active), 0);
        load_bits = '0;
        tick(2);

        // Same-cycle save and load edges
        save_bits = 4'b0001;
        load_bits = 4'b0001;
        push(EV_REJ, 1, cyc + 1);
        tick(4);
        chk("conflict_active", 32'(active), 0);
        chk("conflict_index", 32'(ss_index), 1);
        save_bits = '0;
        load_bits = '0;
        tick(2);

        // Pending queue: slot 0 saved first so its later load is legal
        run_cmd(4'b0001, 4'b0000, 0, EV_SAVE, 3);
        chk("pend_prep_valid", 32'(slot_valid), 32'h7);
        save_bits = 4'b0001;
        push(EV_SAVE, 0, cyc + 2);
        tick(3);
        ss_busy = 1'b1;
        tick(2);
        load_bits = 4'b0001;
        tick(2);
        save_bits = 4'b0011;
        push(EV_REJ, 0, cyc + 1);
        tick(3);
        ss_busy = 1'b0;
        push(EV_REST, 0, cyc + 2);
        tick(3);
        ss_busy = 1'b1;
        tick(2);
        ss_busy = 1'b0;
        tick(2);
        save_bits = '0;
        load_bits = '0;
        tick(2);
        chk("pend_slot_valid", 32'(slot_valid), 32'h7);
        chk("pend_active", 32'(active), 0);

        // Timeout: busy never rises after the slot 3 save
        save_bits = 4'b1000;
        c = cyc;
        push(EV_SAVE, 3, c + 2);
        push(EV_TMO, 3, c + 18);
        tick(20);
        chk("tmo_active", 32'(active), 0);
        chk("tmo_slot_valid", 32'(slot_valid), 32'h7);
        save_bits = '0;
        tick(2);

        // Reset during WAIT_DONE with a queued load and held levels
        save_bits = 4'b0100;
        push(EV_SAVE, 2, cyc + 2);
        tick(3);
        ss_busy = 1'b1;
        tick(3);
        load_bits = 4'b0010;
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("mid_rst_index", 32'(ss_index), 0);
        chk("mid_rst_slot_valid", 32'(slot_valid), 0);
        chk("mid_rst_active", 32'(active), 0);
        ss_busy = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(30);
        chk("post_rst_active", 32'(active), 0);
        chk("post_rst_slot_valid", 32'(slot_valid), 0);
        save_bits = '0;
        load_bits = '0;
        tick(3);

        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d unseen, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
